// File: rtl/traffic_scheduler.sv
// Car-lane sequencer for the frogger road: per-lane positions, step timing,
// level speed-up, pause and frog collision detection in one registered FSM.
module traffic_scheduler #(
    parameter int NUM_LANES   = 4,
    parameter int GRID_MAX    = 20,
    parameter int BASE_PERIOD = 12500000,
    parameter int MAX_LEVEL   = 3
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic                   i_Start,
    input  logic                   i_Pause,
    input  logic                   i_Level_Up,
    input  logic [4:0]             i_Frog_x,
    input  logic [2:0]             i_Frog_lane,
    output logic [5*NUM_LANES-1:0] o_car_x,
    output logic [NUM_LANES-1:0]   o_Step,
    output logic                   o_Hit,
    output logic [1:0]             o_Level,
    output logic                   o_Running,
    output logic [2:0]             o_State
);

    localparam int CNT_W = $clog2(2 * BASE_PERIOD) + 1;
    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_PAUSED = 3'd3,
        S_HIT    = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             level_q, level_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   hit_q, hit_d;
    logic                   running_q, running_d;
    logic [NUM_LANES-1:0]   step_q, step_d;
    logic [4:0]             x_q   [NUM_LANES];
    logic [4:0]             x_d   [NUM_LANES];
    logic [CNT_W-1:0]       cnt_q [NUM_LANES];
    logic [CNT_W-1:0]       cnt_d [NUM_LANES];
    logic                   frog_hit;

    // Odd lanes run at half the rate of even lanes; deep levels floor at 1.
    function automatic logic [CNT_W-1:0] lane_period(input logic odd, input logic [1:0] lvl);
        logic [CNT_W-1:0] p;
        p = CNT_W'(BASE_PERIOD >> lvl);
        if (p == '0) p = CNT_W'(1);
        if (odd) p = p << 1;
        return p;
    endfunction

    function automatic logic [4:0] load_pos(input int k);
        return 5'((7 * k) % (GRID_MAX + 1));
    endfunction

    function automatic logic [4:0] next_pos(input logic odd, input logic [4:0] x);
        if (!odd) return (x == 5'(GRID_MAX)) ? 5'd0 : x + 5'd1;
        return (x == 5'd0) ? 5'(GRID_MAX) : x - 5'd1;
    endfunction

    always_comb begin
        frog_hit = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (i_Frog_lane == 3'(k) && x_q[k] == i_Frog_x) frog_hit = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        idx_d   = idx_q;
        hit_d   = 1'b0;
        step_d  = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            x_d[k]   = x_q[k];
            cnt_d[k] = cnt_q[k];
        end

        case (state_q)
            S_IDLE, S_HIT: begin
                if (i_Start) begin
                    state_d = S_LOAD;
                    level_d = 2'd0;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                for (int k = 0; k < NUM_LANES; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        x_d[k]   = load_pos(k);
                        cnt_d[k] = '0;
                    end
                end
                if (idx_q == IDX_W'(NUM_LANES - 1)) state_d = S_RUN;
                else                                idx_d   = idx_q + 1'b1;
            end
            S_RUN: begin
                // Collision wins over pause, and neither lets lanes step this edge.
                if (frog_hit) begin
                    state_d = S_HIT;
                    hit_d   = 1'b1;
                end else if (i_Pause) begin
                    state_d = S_PAUSED;
                end else begin
                    for (int k = 0; k < NUM_LANES; k++) begin
                        if (cnt_q[k] >= lane_period(k[0], level_q) - 1'b1) begin
                            cnt_d[k]  = '0;
                            step_d[k] = 1'b1;
                            x_d[k]    = next_pos(k[0], x_q[k]);
                        end else begin
                            cnt_d[k] = cnt_q[k] + 1'b1;
                        end
                    end
                end
            end
            S_PAUSED: begin
                if (!i_Pause) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_q == S_RUN || state_q == S_PAUSED) && i_Level_Up &&
            level_q != 2'(MAX_LEVEL)) begin
            level_d = level_q + 2'd1;
        end

        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q   <= S_IDLE;
            level_q   <= 2'd0;
            idx_q     <= '0;
            hit_q     <= 1'b0;
            running_q <= 1'b0;
            step_q    <= '0;
            for (int k = 0; k < NUM_LANES; k++) begin
                x_q[k]   <= 5'd0;
                cnt_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            idx_q     <= idx_d;
            hit_q     <= hit_d;
            running_q <= running_d;
            step_q    <= step_d;
            for (int k = 0; k < NUM_LANES; k++) begin
                x_q[k]   <= x_d[k];
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) o_car_x[5*k +: 5] = x_q[k];
    end

    assign o_Step    = step_q;
    assign o_Hit     = hit_q;
    assign o_Level   = level_q;
    assign o_Running = running_q;
    assign o_State   = state_q;

endmodule

// File: tb/tb_traffic_scheduler.sv
// Self-checking bench for traffic_scheduler with a short base period; lane
// positions are predicted from elapsed run edges and queued before each run.
module tb_traffic_scheduler;

    localparam int NL = 4;
    localparam int GM = 20;
    localparam int BP = 8;

    logic          clk = 1'b0;
    logic          rst_n, start, pause, level_up;
    logic [4:0]    frog_x;
    logic [2:0]    frog_lane;
    logic [5*NL-1:0] car_x;
    logic [NL-1:0] step;
    logic          hit, running;
    logic [1:0]    level;
    logic [2:0]    state;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [19:0] x;
        logic [3:0]  stp;
    } exp_t;

    exp_t sb[$];

    traffic_scheduler #(
        .NUM_LANES(NL), .GRID_MAX(GM), .BASE_PERIOD(BP), .MAX_LEVEL(3)
    ) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start), .i_Pause(pause),
        .i_Level_Up(level_up), .i_Frog_x(frog_x), .i_Frog_lane(frog_lane),
        .o_car_x(car_x), .o_Step(step), .o_Hit(hit), .o_Level(level),
        .o_Running(running), .o_State(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] pack4(input int a0, input int a1, input int a2, input int a3);
        logic [4:0] v0, v1, v2, v3;
        v0 = 5'(a0); v1 = 5'(a1); v2 = 5'(a2); v3 = 5'(a3);
        return {v3, v2, v1, v0};
    endfunction

    // Expected state n run-edges after all lane counters were zero.
    function automatic exp_t expect_run(input int n, input int ep, input int op,
                                        input int b0, input int b1, input int b2, input int b3);
        exp_t e;
        e.x = pack4((b0 + n / ep) % (GM + 1),
                    (((b1 - n / op) % (GM + 1)) + GM + 1) % (GM + 1),
                    (b2 + n / ep) % (GM + 1),
                    (((b3 - n / op) % (GM + 1)) + GM + 1) % (GM + 1));
        e.stp = {(n % op == 0), (n % ep == 0), (n % op == 0), (n % ep == 0)};
        return e;
    endfunction

    task automatic drain_sb(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            total++;
            if (car_x !== e.x || step !== e.stp) begin
                bad++;
                $display("FAIL %s: car_x=%h step=%b expected car_x=%h step=%b",
                         tag, car_x, step, e.x, e.stp);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; pause = 1'b0; level_up = 1'b0;
        frog_x = 5'd0; frog_lane = 3'd7;
        tick(); tick();
        total++;
        if (state !== 3'd0 || car_x !== '0 || step !== '0 || hit !== 1'b0 ||
            level !== 2'd0 || running !== 1'b0) begin
            bad++;
            $display("FAIL reset: state=%0d car_x=%h step=%b hit=%b level=%0d run=%b expected all zero",
                     state, car_x, step, hit, level, running);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (state !== 3'd0) begin
            bad++;
            $display("FAIL idle_hold: state=%0d expected 0", state);
        end
    endtask

    task automatic test_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (state !== 3'd1 || running !== 1'b0) begin
                bad++;
                $display("FAIL load_state[%0d]: state=%0d run=%b expected 1 0", i, state, running);
            end
            if (i < 3) tick();
        end
        tick();
        total++;
        if (state !== 3'd2 || running !== 1'b1 || car_x !== pack4(0, 7, 14, 0)) begin
            bad++;
            $display("FAIL load_done: state=%0d run=%b car_x=%h expected 2 1 %h",
                     state, running, car_x, pack4(0, 7, 14, 0));
        end
    endtask

    task automatic test_step();
        for (int n = 1; n <= 16; n++) sb.push_back(expect_run(n, BP, 2 * BP, 0, 7, 14, 0));
        drain_sb("step_lvl0");
        total++;
        if (car_x !== pack4(2, 6, 16, 20)) begin
            bad++;
            $display("FAIL step_wrap: car_x=%h expected %h", car_x, pack4(2, 6, 16, 20));
        end
    endtask

    task automatic test_level();
        logic [1:0] want;
        pause = 1'b1;
        tick();
        total++;
        if (state !== 3'd3 || running !== 1'b0 || step !== '0) begin
            bad++;
            $display("FAIL pause_enter: state=%0d run=%b step=%b expected 3 0 0", state, running, step);
        end
        level_up = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            want = (i > 3) ? 2'd3 : 2'(i);
            total++;
            if (level !== want) begin
                bad++;
                $display("FAIL level_up[%0d]: level=%0d expected %0d", i, level, want);
            end
        end
        level_up = 1'b0;
        pause = 1'b0;
        tick();
        total++;
        if (state !== 3'd2 || step !== '0) begin
            bad++;
            $display("FAIL resume: state=%0d step=%b expected 2 0", state, step);
        end
        for (int n = 1; n <= 6; n++) sb.push_back(expect_run(n, 1, 2, 2, 6, 16, 20));
        drain_sb("step_lvl3");
    endtask

    task automatic test_pause();
        tick();
        total++;
        if (car_x !== pack4(9, 3, 2, 17) || step !== 4'b0101) begin
            bad++;
            $display("FAIL pre_pause: car_x=%h step=%b expected %h 0101", car_x, step, pack4(9, 3, 2, 17));
        end
        pause = 1'b1;
        for (int i = 0; i < 20; i++) sb.push_back('{x: pack4(9, 3, 2, 17), stp: 4'b0000});
        drain_sb("paused");
        pause = 1'b0;
        tick();
        tick();
        total++;
        if (car_x !== pack4(10, 2, 3, 16) || step !== 4'b1111) begin
            bad++;
            $display("FAIL pause_resume: car_x=%h step=%b expected %h 1111", car_x, step, pack4(10, 2, 3, 16));
        end
    endtask

    task automatic test_hit();
        frog_lane = 3'd0;
        frog_x = 5'd12;
        tick();
        tick();
        total++;
        if (hit !== 1'b0 || state !== 3'd2) begin
            bad++;
            $display("FAIL pre_hit: hit=%b state=%0d expected 0 2", hit, state);
        end
        tick();
        total++;
        if (hit !== 1'b1 || state !== 3'd4 || running !== 1'b0 || step !== '0 ||
            car_x !== pack4(12, 1, 5, 15)) begin
            bad++;
            $display("FAIL hit_pulse: hit=%b state=%0d run=%b step=%b car_x=%h expected 1 4 0 0 %h",
                     hit, state, running, step, car_x, pack4(12, 1, 5, 15));
        end
        level_up = 1'b1;
        tick();
        level_up = 1'b0;
        tick(); tick();
        total++;
        if (hit !== 1'b0 || state !== 3'd4 || level !== 2'd3 || car_x !== pack4(12, 1, 5, 15)) begin
            bad++;
            $display("FAIL hit_hold: hit=%b state=%0d level=%0d car_x=%h expected 0 4 3 %h",
                     hit, state, level, car_x, pack4(12, 1, 5, 15));
        end
        frog_lane = 3'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (state !== 3'd1 || level !== 2'd0) begin
            bad++;
            $display("FAIL restart: state=%0d level=%0d expected 1 0", state, level);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (state !== 3'd2 || car_x !== pack4(0, 7, 14, 0)) begin
            bad++;
            $display("FAIL reload: state=%0d car_x=%h expected 2 %h", state, car_x, pack4(0, 7, 14, 0));
        end
        for (int n = 1; n <= 8; n++) sb.push_back(expect_run(n, BP, 2 * BP, 0, 7, 14, 0));
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (state !== 3'd2) begin
            bad++;
            $display("FAIL start_in_run: state=%0d expected 2", state);
        end
        void'(sb.pop_front());
        drain_sb("restart_run");
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if (state !== 3'd0 || car_x !== '0 || step !== '0 || hit !== 1'b0 ||
            level !== 2'd0 || running !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: state=%0d car_x=%h step=%b hit=%b level=%0d run=%b expected all zero",
                     state, car_x, step, hit, level, running);
        end
        tick();
        total++;
        if (state !== 3'd0 || step !== '0) begin
            bad++;
            $display("FAIL reset_stay: state=%0d step=%b expected 0 0", state, step);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_step();
        test_level();
        test_pause();
        test_hit();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
